sumador_arbiter: RTL and testbench

- Shares one 14-bit add/subtract datapath among `N` requesters using round-robin arbitration.
- Each requester presents two operands and an operation select.
- The block grants one requester at a time, computes `a+b` or `a-b`, and returns a registered, tagged result under a valid/ready handshake.
- It sits between the requesting control units and the adder, and is the only path into the adder.

---
 rtl/sumador_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_sumador_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_arbiter.sv
// -----------------------------------------------------------------------------
// sumador_arbiter
// Round-robin arbiter in front of a single W-bit add/subtract datapath. One
// requester is granted at a time; its operands are captured, the result is
// computed in the following cycle and held, tagged with the requester index,
// until the consumer accepts it.
//
// Optional feature macro: SUMADOR_ARB_FLAGS_EN
//   defined   : res_carry / res_ovf are computed and registered
//   undefined : res_carry / res_ovf are tied to 0 and no flag logic is built
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [N]     per-requester request
//   a_in       in   [N*W]   operand A, requester i at [i*W +: W]
//   b_in       in   [N*W]   operand B, same packing
//   oper_in    in   [N]     0 = add, 1 = subtract
//   grant      out  [N]     one-hot, one-cycle acceptance pulse
//   res        out  [W]     result modulo 2^W
//   res_id     out  [IDW]   index of the requester owning res
//   res_carry  out          add carry / subtract borrow (unsigned a<b)
//   res_ovf    out          two's-complement overflow
//   res_valid  out          result available
//   res_ready  in           consumer accepts result
// -----------------------------------------------------------------------------
module sumador_arbiter #(
  parameter int N   = 4,
  parameter int W   = 14,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  input  logic [N-1:0]     oper_in,
  output logic [N-1:0]     grant,
  output logic [W-1:0]     res,
  output logic [IDW-1:0]   res_id,
  output logic             res_carry,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic           op_sub_q, op_sub_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   res_q, res_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_valid_q, res_valid_d;

  logic           win_found_s;
  logic [IDW-1:0] win_idx_s;
  logic [IDW-1:0] cand_s;
  logic [W-1:0]   sum_s;

`ifdef SUMADOR_ARB_FLAGS_EN
  logic [W:0]     add_ext_s;
  logic           carry_s, ovf_s;
  logic           carry_q, carry_d;
  logic           ovf_q, ovf_d;
`endif

  // Round-robin winner search: first set req scanning upward from ptr with wrap.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = IDW'((32'(ptr_q) + 32'(k)) % 32'(N));
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Shared adder/subtractor working on the captured operands.
  always_comb begin
`ifdef SUMADOR_ARB_FLAGS_EN
    add_ext_s = {1'b0, op_a_q} + {1'b0, op_b_q};
`endif
    if (op_sub_q) begin
      sum_s = op_a_q - op_b_q;
    end else begin
`ifdef SUMADOR_ARB_FLAGS_EN
      sum_s = add_ext_s[W-1:0];
`else
      sum_s = op_a_q + op_b_q;
`endif
    end
  end

`ifdef SUMADOR_ARB_FLAGS_EN
  // Carry/borrow and signed-overflow flags from operand and result sign bits.
  always_comb begin
    if (op_sub_q) begin
      carry_s = (op_a_q < op_b_q);
      ovf_s   = (op_a_q[W-1] != op_b_q[W-1]) && (sum_s[W-1] != op_a_q[W-1]);
    end else begin
      carry_s = add_ext_s[W];
      ovf_s   = (op_a_q[W-1] == op_b_q[W-1]) && (sum_s[W-1] != op_a_q[W-1]);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the grant, capture and result registers.
  always_comb begin
    grant_d     = '0;
    ptr_d       = ptr_q;
    op_id_d     = op_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sub_d    = op_sub_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
`ifdef SUMADOR_ARB_FLAGS_EN
    carry_d     = carry_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_d  = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
          ptr_d    = (win_idx_s == IDW'(N-1)) ? '0 : win_idx_s + IDW'(1);
          op_id_d  = win_idx_s;
          op_a_d   = a_in[win_idx_s*W +: W];
          op_b_d   = b_in[win_idx_s*W +: W];
          op_sub_d = oper_in[win_idx_s];
        end else begin
          grant_d  = '0;
        end
      end
      ST_EXEC: begin
        res_d       = sum_s;
        res_id_d    = op_id_q;
        res_valid_d = 1'b1;
`ifdef SUMADOR_ARB_FLAGS_EN
        carry_d     = carry_s;
        ovf_d       = ovf_s;
`endif
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        grant_d     = '0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      op_id_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= 1'b0;
      grant_q     <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
`ifdef SUMADOR_ARB_FLAGS_EN
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      op_id_q     <= op_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sub_q    <= op_sub_d;
      grant_q     <= grant_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
`ifdef SUMADOR_ARB_FLAGS_EN
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
`ifdef SUMADOR_ARB_FLAGS_EN
  assign res_carry = carry_q;
  assign res_ovf   = ovf_q;
`else
  assign res_carry = 1'b0;
  assign res_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_sumador_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sumador_arbiter
// Scoreboard bench: the stimulus process predicts each grant from its own
// round-robin model and queues the arithmetic result expected for it; an
// independent monitor pops and compares whenever a new result is presented.
// -----------------------------------------------------------------------------
module tb_sumador_arbiter;
  localparam int N   = 4;
  localparam int W   = 14;
  localparam int IDW = 2;
`ifdef SUMADOR_ARB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in, b_in;
  logic [N-1:0]     oper_in;
  logic [N-1:0]     grant;
  logic [W-1:0]     res;
  logic [IDW-1:0]   res_id;
  logic             res_carry, res_ovf, res_valid;
  logic             res_ready;

  sumador_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .oper_in(oper_in), .grant(grant), .res(res), .res_id(res_id),
    .res_carry(res_carry), .res_ovf(res_ovf), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int res; int c; int o; } exp_t;

  exp_t sb_q[$];
  int   grant_ids[$];
  int   grant_cycs[$];
  int   tests = 0;
  int   fails = 0;
  int   pa[N], pb[N];
  bit   pop[N], pend[N];
  int   ptr_m = 0;
  bit   rerequest = 1'b0;
  bit   rand_mode = 1'b0;
  int   last_res, last_id, last_c, last_o;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers, signed range checked directly.
  function automatic exp_t model(input int id, input int a, input int b, input bit sub);
    exp_t e;
    int m, h, raw, sa, sb, st;
    m  = 1 << W;
    h  = 1 << (W - 1);
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    if (!sub) begin
      raw = a + b;  e.c = (raw >= m) ? 1 : 0;  st = sa + sb;
    end else begin
      raw = a - b;  e.c = (a < b) ? 1 : 0;     st = sa - sb;
    end
    e.id  = id;
    e.res = ((raw % m) + m) % m;
    e.o   = (st < -h || st > h - 1) ? 1 : 0;
    if (!FL) begin
      e.c = 0;
      e.o = 0;
    end
    return e;
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return (1 << W) - 1;
      2: return (1 << (W - 1)) - 1;
      3: return 1 << (W - 1);
      default: return int'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) r |= pend[i];
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]          = pend[i];
      a_in[i*W +: W]  = W'(pa[i]);
      b_in[i*W +: W]  = W'(pb[i]);
      oper_in[i]      = pop[i];
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit sub);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; pop[i] = sub;
  endtask

  task automatic new_req(input int i);
    set_req(i, pick(), pick(), 1'($urandom_range(0, 1)));
  endtask

  // One clock: check any grant against the model, queue its result, re-drive.
  task automatic tick();
    int w;
    @(posedge clk); #2;
    if (grant !== '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && pend[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      chk("grant_winner", 64'(grant), (w < 0) ? 64'd0 : (64'd1 << w));
      grant_ids.push_back(w);
      grant_cycs.push_back(cyc);
      if (w >= 0) begin
        sb_q.push_back(model(w, pa[w], pb[w], pop[w]));
        ptr_m   = (w + 1) % N;
        pend[w] = 1'b0;
        if (rerequest) new_req(w);
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      res_ready = ($urandom_range(0, 9) < 7);
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_outputs_zero", 64'({grant, res, res_id, res_carry, res_ovf, res_valid}), 64'd0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    ptr_m = 0;
    sb_q.delete();
    grant_ids.delete();
    grant_cycs.delete();
    drive();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (t < budget && (any_pend() || sb_q.size() != 0 || res_valid !== 1'b0)) begin
      tick();
      t++;
    end
    chk(name, 64'(t < budget), 64'd1);
  endtask

  // Monitor: compare each newly presented result, then watch it stay stable.
  initial begin
    bit   checked = 1'b0;
    exp_t e;
    logic [W-1:0]   held_res;
    logic [IDW-1:0] held_id;
    forever begin
      @(negedge clk);
      if (rst) begin
        checked = 1'b0;
      end else begin
        if (res_valid === 1'b1 && !checked) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            chk("res_value", 64'(res), 64'(e.res));
            chk("res_id", 64'(res_id), 64'(e.id));
            chk("res_carry", 64'(res_carry), 64'(e.c));
            chk("res_ovf", 64'(res_ovf), 64'(e.o));
          end
          last_res = int'(res); last_id = int'(res_id);
          last_c = int'(res_carry); last_o = int'(res_ovf);
          held_res = res; held_id = res_id;
          checked = 1'b1;
        end else if (res_valid === 1'b1) begin
          chk("hold_stable", 64'({res, res_id}), 64'({held_res, held_id}));
        end
        chk("no_grant_while_valid", 64'(grant & {N{res_valid}}), 64'd0);
        if (res_valid === 1'b1 && res_ready === 1'b1) checked = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0;
    for (int i = 0; i < N; i++) begin pa[i] = 0; pb[i] = 0; pop[i] = 1'b0; pend[i] = 1'b0; end
    res_ready = 1'b1;
    drive();
    #1;
    do_reset();

    // Directed arithmetic cases with spec-given constants.
    set_req(0, 100, 23, 1'b0); drive();
    wait_idle(20, "single_done");
    chk("single_res_const", 64'(last_res), 64'd123);
    chk("single_id_const", 64'(last_id), 64'd0);
    chk("single_flags_const", 64'({last_c[0], last_o[0]}), 64'd0);

    set_req(2, 5, 10, 1'b1); drive();
    wait_idle(20, "sub_done");
    chk("sub_res_const", 64'(last_res), 64'd16379);
    chk("sub_carry_const", 64'(last_c), FL ? 64'd1 : 64'd0);
    chk("sub_ovf_const", 64'(last_o), 64'd0);

    set_req(3, 8191, 1, 1'b0); drive();
    wait_idle(20, "ovf_done");
    chk("ovf_res_const", 64'(last_res), 64'd8192);
    chk("ovf_ovf_const", 64'(last_o), FL ? 64'd1 : 64'd0);
    chk("ovf_carry_const", 64'(last_c), 64'd0);

    // Round robin with every requester continuously requesting.
    do_reset();
    res_ready = 1'b1;
    rerequest = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    drive();
    for (int t = 0; t < 40 && grant_ids.size() < 5; t++) tick();
    rerequest = 1'b0;
    chk("rr_grants_seen", 64'(grant_ids.size() >= 5), 64'd1);
    if (grant_ids.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(grant_ids[i]), 64'(i % N));
      for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(grant_cycs[i] - grant_cycs[i-1]), 64'd3);
    end
    wait_idle(40, "rr_drain");

    // Backpressure with other requests pending.
    do_reset();
    res_ready = 1'b0;
    set_req(0, 300, 4000, 1'b0);
    set_req(1, 7, 9000, 1'b1);
    set_req(2, 16383, 16383, 1'b0);
    drive();
    for (int t = 0; t < 10 && res_valid !== 1'b1; t++) tick();
    chk("bp_valid_seen", 64'(res_valid), 64'd1);
    n0 = grant_ids.size();
    for (int t = 0; t < 5; t++) tick();
    chk("bp_no_grant", 64'(grant_ids.size()), 64'(n0));
    chk("bp_valid_held", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    drive();
    c0 = cyc;
    for (int t = 0; t < 10 && grant_ids.size() == n0; t++) tick();
    if (grant_ids.size() > n0) chk("bp_release_gap", 64'(grant_cycs[n0] - c0), 64'd2);
    else chk("bp_release_grant", 64'(grant_ids.size()), 64'(n0 + 1));

    // Reset while a result is held.
    res_ready = 1'b0;
    drive();
    for (int t = 0; t < 10 && res_valid !== 1'b1; t++) tick();
    chk("hold_reached", 64'(res_valid), 64'd1);
    do_reset();
    res_ready = 1'b1;
    set_req(1, 11, 22, 1'b0);
    set_req(3, 33, 44, 1'b1);
    drive();
    for (int t = 0; t < 10 && grant_ids.size() == 0; t++) tick();
    chk("post_rst_grant_seen", 64'(grant_ids.size() > 0), 64'd1);
    if (grant_ids.size() > 0) chk("post_rst_first_id", 64'(grant_ids[0]), 64'd1);
    wait_idle(30, "post_rst_drain");

    // Randomized traffic with random backpressure.
    rand_mode = 1'b1;
    for (int t = 0; t < 600; t++) tick();
    rand_mode = 1'b0;
    res_ready = 1'b1;
    drive();
    wait_idle(80, "random_drain");
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
